posit_sum_encode_es2: RTL and testbench



---
 rtl/posit_sum_encode_es2_if.sv | 24 ++
 rtl/posit_sum_encode_es2.sv | 192 +++++++++++++++++++
 tb/tb_posit_sum_encode_es2.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_sum_encode_es2_if.sv
// Valid/ready bus carrying raw es=2 adder sums into the posit encoder and
// encoded posits out toward result writeback.
interface posit_sum_encode_es2_if #(
  parameter int N = 32
);
  logic         start;
  logic [40:0]  in_sum;
  logic         in_truncated;
  logic         in_ready;
  logic [N-1:0] result;
  logic         done;
  logic         inexact;
  logic         out_ready;

  modport master (
    output start, in_sum, in_truncated, out_ready,
    input  in_ready, result, done, inexact
  );

  modport slave (
    input  start, in_sum, in_truncated, out_ready,
    output in_ready, result, done, inexact
  );
endinterface

// File: rtl/posit_sum_encode_es2.sv
// Encodes a raw es=2 posit adder sum into an N-bit posit with round-to-nearest-even.
// Three register stages (clamp, regime build, round) share one global advance enable.
module posit_sum_encode_es2 #(
  parameter int N = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  posit_sum_encode_es2_if.slave  bus
);
  localparam int                 MAX_SCALE = 4 * (N - 2);
  localparam logic signed [7:0]  MAX_S     = 8'(MAX_SCALE);
  localparam logic signed [7:0]  MIN_S     = 8'(-MAX_SCALE);
  localparam int                 XW        = 64;
  localparam logic [N-2:0]       MAXPOS    = {(N-1){1'b1}};
  localparam logic [N-2:0]       MINPOS    = {{(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0]       NAR       = {1'b1, {(N-1){1'b0}}};

  logic               adv_s;
  logic signed [7:0]  scale_s, sclamp_s;
  logic               chi_s, clo_s;

  logic               s1_valid_r, s1_sign_r, s1_inf_r, s1_zero_r, s1_trunc_r;
  logic               s1_chi_r, s1_clo_r;
  logic [29:0]        s1_frac_r;
  logic signed [7:0]  s1_k_r;
  logic [1:0]         s1_e_r;

  logic [5:0]         rlen_s;
  logic [XW-1:0]      tail_s, mask_s, str_s;
  logic [N-2:0]       mag_next_s;
  logic               g_next_s, st_next_s;

  logic               s2_valid_r, s2_sign_r, s2_inf_r, s2_zero_r, s2_chi_r, s2_clo_r;
  logic [N-2:0]       s2_mag_r;
  logic               s2_g_r, s2_st_r;

  logic               rup_s, inx_s, out_inx_s;
  logic [N-1:0]       sum_s, signed_s, out_res_s;
  logic [N-2:0]       rounded_s, fmag_s;

  logic               done_r, inexact_r;
  logic [N-1:0]       result_r;

  // A held output freezes the whole pipe; bubbles travel like data.
  assign adv_s        = ~done_r | bus.out_ready;
  assign bus.in_ready = adv_s;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.inexact  = inexact_r;

  // Clamp the incoming scale into the representable regime range.
  always_comb begin
    scale_s  = $signed(bus.in_sum[39:32]);
    chi_s    = 1'b0;
    clo_s    = 1'b0;
    sclamp_s = scale_s;
    if (scale_s > MAX_S) begin
      chi_s    = 1'b1;
      sclamp_s = MAX_S;
    end else if (scale_s < MIN_S) begin
      clo_s    = 1'b1;
      sclamp_s = MIN_S;
    end else begin
      sclamp_s = scale_s;
    end
  end

  // Stage 1 register: captured fields, regime count k and exponent e.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_inf_r   <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_trunc_r <= 1'b0;
      s1_chi_r   <= 1'b0;
      s1_clo_r   <= 1'b0;
      s1_frac_r  <= 30'd0;
      s1_k_r     <= 8'sd0;
      s1_e_r     <= 2'd0;
    end else if (adv_s) begin
      s1_valid_r <= bus.start;
      s1_sign_r  <= bus.in_sum[40];
      s1_inf_r   <= bus.in_sum[1];
      s1_zero_r  <= bus.in_sum[0];
      s1_trunc_r <= bus.in_truncated;
      s1_chi_r   <= chi_s;
      s1_clo_r   <= clo_s;
      s1_frac_r  <= bus.in_sum[31:2];
      s1_k_r     <= sclamp_s >>> 2;
      s1_e_r     <= sclamp_s[1:0];
    end
  end

  // Regime is built by shifting {terminator, e, frac} right and filling with
  // ones (k >= 0) or zeros (k < 0); string MSB sits at magnitude bit N-2.
  always_comb begin
    if (s1_k_r[7]) begin
      rlen_s = 6'(-s1_k_r);
      mask_s = {XW{1'b0}};
    end else begin
      rlen_s = 6'(s1_k_r + 8'sd1);
      mask_s = ~({XW{1'b1}} >> rlen_s);
    end
    tail_s     = {s1_k_r[7], s1_e_r, s1_frac_r, {(XW-33){1'b0}}};
    str_s      = (tail_s >> rlen_s) | mask_s;
    mag_next_s = str_s[XW-1 -: N-1];
    g_next_s   = str_s[XW-N];
    st_next_s  = (|str_s[XW-N-1:0]) | s1_trunc_r;
  end

  // Stage 2 register: unrounded magnitude with guard and sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_inf_r   <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_chi_r   <= 1'b0;
      s2_clo_r   <= 1'b0;
      s2_mag_r   <= {(N-1){1'b0}};
      s2_g_r     <= 1'b0;
      s2_st_r    <= 1'b0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_sign_r  <= s1_sign_r;
      s2_inf_r   <= s1_inf_r;
      s2_zero_r  <= s1_zero_r;
      s2_chi_r   <= s1_chi_r;
      s2_clo_r   <= s1_clo_r;
      s2_mag_r   <= mag_next_s;
      s2_g_r     <= g_next_s;
      s2_st_r    <= st_next_s;
    end
  end

  // Round to nearest even, saturate to maxpos/minpos, apply sign and specials.
  always_comb begin
    rup_s     = s2_g_r & (s2_mag_r[0] | s2_st_r);
    sum_s     = {1'b0, s2_mag_r} + {{(N-1){1'b0}}, rup_s};
    rounded_s = sum_s[N-2:0];
    if (s2_chi_r) begin
      fmag_s = MAXPOS;
      inx_s  = 1'b1;
    end else if (s2_clo_r) begin
      fmag_s = MINPOS;
      inx_s  = 1'b1;
    end else if (sum_s[N-1]) begin
      fmag_s = MAXPOS;
      inx_s  = s2_g_r | s2_st_r;
    end else if (rounded_s == {(N-1){1'b0}}) begin
      fmag_s = MINPOS;
      inx_s  = s2_g_r | s2_st_r;
    end else begin
      fmag_s = rounded_s;
      inx_s  = s2_g_r | s2_st_r;
    end
    if (s2_sign_r) begin
      signed_s = ~{1'b0, fmag_s} + {{(N-1){1'b0}}, 1'b1};
    end else begin
      signed_s = {1'b0, fmag_s};
    end
    if (s2_inf_r) begin
      out_res_s = NAR;
      out_inx_s = 1'b0;
    end else if (s2_zero_r) begin
      out_res_s = {N{1'b0}};
      out_inx_s = 1'b0;
    end else begin
      out_res_s = signed_s;
      out_inx_s = inx_s;
    end
  end

  // Output register; bubbles load a cleared result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r    <= 1'b0;
      result_r  <= {N{1'b0}};
      inexact_r <= 1'b0;
    end else if (adv_s) begin
      done_r <= s2_valid_r;
      if (s2_valid_r) begin
        result_r  <= out_res_s;
        inexact_r <= out_inx_s;
      end else begin
        result_r  <= {N{1'b0}};
        inexact_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_posit_sum_encode_es2.sv
// Scoreboard bench for posit_sum_encode_es2 (N=32): directed vectors push
// expected results; an independent monitor pops and compares on each output.
module tb_posit_sum_encode_es2;
  localparam int N = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   or_mode = 1'b0;
  logic [32:0] exp_q[$];

  posit_sum_encode_es2_if #(.N(N)) bus ();

  posit_sum_encode_es2 #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [40:0] mk(input logic sg, input logic [7:0] sc,
                                     input logic [29:0] fr, input logic inf, input logic zr);
    return {sg, sc, fr, inf, zr};
  endfunction

  // out_ready: constantly high, or a fixed pseudo-random pattern
  initial begin
    logic [15:0] pat;
    int idx;
    pat = 16'b1011_0010_0110_1001;
    idx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (or_mode) begin
        bus.out_ready = pat[idx % 16];
        idx++;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops, stall hold and in_ready behaviour
  initial begin
    bit held;
    logic [31:0] hres;
    logic hinx;
    logic [32:0] e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check32("hold_result", bus.result, hres);
          check1("hold_inexact", bus.inexact, hinx);
          check1("hold_done", bus.done, 1'b1);
        end
        if (bus.done && !bus.out_ready) begin
          check1("in_ready_stall", bus.in_ready, 1'b0);
          held = 1'b1;
          hres = bus.result;
          hinx = bus.inexact;
        end else begin
          held = 1'b0;
        end
        if (bus.done && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%08h with nothing outstanding", bus.result);
          end else begin
            e = exp_q.pop_front();
            check32("result", bus.result, e[32:1]);
            check1("inexact", bus.inexact, e[0]);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [40:0] sum, input logic tr, input logic [31:0] er, input logic ei);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    bus.start = 1'b1;
    bus.in_sum = sum;
    bus.in_truncated = tr;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back({er, ei});
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    bus.in_truncated = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_timed(input logic [40:0] sum, input logic [31:0] er);
    send(sum, 1'b0, er, 1'b0);
    @(negedge clk); check1("latency_c1_done", bus.done, 1'b0);
    @(negedge clk); check1("latency_c2_done", bus.done, 1'b0);
    @(negedge clk); check1("latency_c3_done", bus.done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit saw;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.in_sum = 41'd0;
    bus.in_truncated = 1'b0;
    #12;
    check1("reset_done", bus.done, 1'b0);
    check32("reset_result", bus.result, 32'h0000_0000);
    check1("reset_inexact", bus.inexact, 1'b0);
    check1("reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic encodes with latency
    send_timed(mk(1'b0, 8'd0,   30'h0,        1'b0, 1'b0), 32'h4000_0000);
    send_timed(mk(1'b1, 8'd0,   30'h0,        1'b0, 1'b0), 32'hC000_0000);
    send_timed(mk(1'b0, 8'd0,   30'h2000_0000, 1'b0, 1'b0), 32'h4400_0000);
    send_timed(mk(1'b0, 8'd4,   30'h0,        1'b0, 1'b0), 32'h6000_0000);
    send_timed(mk(1'b0, 8'hFF,  30'h0,        1'b0, 1'b0), 32'h3800_0000);

    // Rounding, saturation, specials and scale boundaries, back to back
    send(mk(1'b0, 8'd0,  30'h4, 1'b0, 1'b0), 1'b0, 32'h4000_0000, 1'b1);
    send(mk(1'b0, 8'd0,  30'h6, 1'b0, 1'b0), 1'b0, 32'h4000_0001, 1'b1);
    send(mk(1'b0, 8'd0,  30'h4, 1'b0, 1'b0), 1'b1, 32'h4000_0001, 1'b1);
    send(mk(1'b0, 8'd0,  30'hC, 1'b0, 1'b0), 1'b0, 32'h4000_0002, 1'b1);
    send(mk(1'b0, 8'h7F, 30'h0, 1'b0, 1'b0), 1'b0, 32'h7FFF_FFFF, 1'b1);
    send(mk(1'b0, 8'h80, 30'h0, 1'b0, 1'b0), 1'b0, 32'h0000_0001, 1'b1);
    send(mk(1'b1, 8'h80, 30'h0, 1'b0, 1'b0), 1'b0, 32'hFFFF_FFFF, 1'b1);
    send(mk(1'b1, 8'h7F, 30'h0, 1'b0, 1'b0), 1'b0, 32'h8000_0001, 1'b1);
    send(mk(1'b1, 8'h35, 30'h123_4567, 1'b0, 1'b1), 1'b1, 32'h0000_0000, 1'b0);
    send(mk(1'b0, 8'h12, 30'h0AB_CDEF, 1'b1, 1'b1), 1'b0, 32'h8000_0000, 1'b0);
    send(mk(1'b0, 8'h78, 30'h0, 1'b0, 1'b0), 1'b0, 32'h7FFF_FFFF, 1'b0);
    send(mk(1'b0, 8'h79, 30'h0, 1'b0, 1'b0), 1'b0, 32'h7FFF_FFFF, 1'b1);
    send(mk(1'b0, 8'h88, 30'h0, 1'b0, 1'b0), 1'b0, 32'h0000_0001, 1'b0);
    send(mk(1'b0, 8'h87, 30'h0, 1'b0, 1'b0), 1'b0, 32'h0000_0001, 1'b1);
    send(mk(1'b0, 8'h8B, 30'h0, 1'b0, 1'b0), 1'b0, 32'h0000_0002, 1'b1);
    drain();

    // Back-pressure stream of 8 distinct items
    or_mode = 1'b1;
    send(mk(1'b0, 8'd1,  30'h0,         1'b0, 1'b0), 1'b0, 32'h4800_0000, 1'b0);
    send(mk(1'b0, 8'd2,  30'h0,         1'b0, 1'b0), 1'b0, 32'h5000_0000, 1'b0);
    send(mk(1'b1, 8'd4,  30'h0,         1'b0, 1'b0), 1'b0, 32'hA000_0000, 1'b0);
    send(mk(1'b0, 8'd8,  30'h0,         1'b0, 1'b0), 1'b0, 32'h7000_0000, 1'b0);
    send(mk(1'b0, 8'hFC, 30'h0,         1'b0, 1'b0), 1'b0, 32'h2000_0000, 1'b0);
    send(mk(1'b0, 8'hF8, 30'h0,         1'b0, 1'b0), 1'b0, 32'h1000_0000, 1'b0);
    send(mk(1'b1, 8'hFF, 30'h0,         1'b0, 1'b0), 1'b0, 32'hC800_0000, 1'b0);
    send(mk(1'b0, 8'd0,  30'h1000_0000, 1'b0, 1'b0), 1'b0, 32'h4200_0000, 1'b0);
    drain();
    or_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three items in flight
    send(mk(1'b0, 8'd4, 30'h0, 1'b0, 1'b0), 1'b0, 32'h6000_0000, 1'b0);
    send(mk(1'b0, 8'd1, 30'h0, 1'b0, 1'b0), 1'b0, 32'h4800_0000, 1'b0);
    send(mk(1'b1, 8'd0, 30'h0, 1'b0, 1'b0), 1'b0, 32'hC000_0000, 1'b0);
    check1("pre_reset_done", bus.done, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check1("midrst_done", bus.done, 1'b0);
    check32("midrst_result", bus.result, 32'h0000_0000);
    check1("midrst_inexact", bus.inexact, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check1("post_rst_in_ready", bus.in_ready, 1'b1);
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) saw = 1'b1;
    end
    check1("no_stale_output", saw, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
